// File: rtl/pcfg_pkg.sv
// pcfg_pkg
//   Shared definitions for the processor config register arbiter:
//   - state_t : FSM encodings ST_IDLE / ST_ACC / ST_DONE
//   - clog2   : sizes the round-robin pointer and grant index (never below 1 bit)
package pcfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2 with a floor of 1, so a single-requester build still gets
  // a legal one-bit pointer.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pcfg_rr_pick.sv
// pcfg_rr_pick
//   Combinational round-robin picker: scans the request vector upward from
//   the round-robin pointer (wrapping mod NREQ) and returns the first valid one.
// Ports:
//   req_vld  in   NREQ  per-requester valid
//   rr_ptr   in   PW    requester with highest priority this round
//   grant    out  PW    index of the selected requester (0 when none)
//   any_vld  out  1     at least one requester is valid
module pcfg_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_vld,
  input  logic [PW-1:0]   rr_ptr,
  output logic [PW-1:0]   grant,
  output logic            any_vld
);

  // The first hit wins; later hits in the scan are ignored once any_vld is set.
  always_comb begin : scan
    int idx;
    idx     = 0;
    grant   = '0;
    any_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any_vld && req_vld[idx]) begin
        any_vld = 1'b1;
        grant   = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/pcfg_arb.sv
// pcfg_arb
//   Arbitrated access controller for a bank of config registers. Requesters
//   are served round-robin; each access runs IDLE -> ACC -> DONE -> IDLE.
//   The selected request is latched in IDLE directly into the bank-facing
//   registers (upen/upws/updi), read data is captured at the end of ACC and
//   returned with a one-cycle ack in DONE.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   req_vld    in   NREQ     request valid (level, held until ack)
//   req_wr     in   NREQ     1 = write, 0 = read
//   req_addr   in   NREQ*AW  requester i address at [i*AW +: AW]
//   req_wdat   in   NREQ*DW  requester i write data at [i*DW +: DW]
//   req_ack    out  NREQ     one-cycle completion pulse
//   req_rdat   out  DW       read data, valid with req_ack
//   upen       out  NREG     one-hot register enable (only in ACC)
//   upws       out  1        write strobe (only in ACC)
//   updi       out  DW       write data (only in ACC)
//   updo_or    in   DW       OR of all register read outputs
//   busy       out  1        access in progress (ACC or DONE)
//   req_err    out  1        only with PCFG_ARB_ERR_EN: pulses with req_ack
//                            when the access address was >= NREG
// Configuration macro: PCFG_ARB_ERR_EN
module pcfg_arb
  import pcfg_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 4,
  parameter int DW   = 8,
  parameter int NREG = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdat,
  output logic [NREQ-1:0]   req_ack,
  output logic [DW-1:0]     req_rdat,
  output logic [NREG-1:0]   upen,
  output logic              upws,
  output logic [DW-1:0]     updi,
  input  logic [DW-1:0]     updo_or,
`ifdef PCFG_ARB_ERR_EN
  output logic              req_err,
`endif
  output logic              busy
);

  localparam int PW = clog2(NREQ);

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gnt;
  logic [PW-1:0]     pick;
  logic              any_vld;
  logic [AW-1:0]     sel_addr;
  logic [NREG-1:0]   sel_dec;
  logic [NREQ-1:0]   ack_onehot;
  logic [PW-1:0]     rr_next;

  pcfg_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_vld (req_vld),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_vld (any_vld)
  );

  assign sel_addr = req_addr[int'(pick)*AW +: AW];

  // Address decoder: out-of-range addresses match no register, which is
  // what drops such writes and makes their reads return 0.
  always_comb begin
    sel_dec = '0;
    for (int r = 0; r < NREG; r++) begin
      if (sel_addr == AW'(r)) sel_dec[r] = 1'b1;
    end
  end

  // Ack goes to the requester latched at grant time, not to whoever the
  // picker currently favours.
  always_comb begin
    ack_onehot      = '0;
    ack_onehot[gnt] = 1'b1;
  end

  assign rr_next = (gnt == PW'(NREQ - 1)) ? '0 : gnt + PW'(1);
  assign busy    = (state != ST_IDLE);

  // Main FSM. The bank-facing registers double as the latched request: they
  // are loaded in IDLE and cleared when ACC ends. An out-of-range access is
  // recognised in ACC by upen being all zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      upen     <= '0;
      upws     <= 1'b0;
      updi     <= '0;
      req_ack  <= '0;
      req_rdat <= '0;
`ifdef PCFG_ARB_ERR_EN
      req_err  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_vld) begin
            gnt   <= pick;
            upen  <= sel_dec;
            upws  <= req_wr[pick];
            updi  <= req_wdat[int'(pick)*DW +: DW];
            state <= ST_ACC;
          end
        end
        ST_ACC: begin
          req_rdat <= updo_or;
          req_ack  <= ack_onehot;
`ifdef PCFG_ARB_ERR_EN
          req_err  <= (upen == '0);
`endif
          upen     <= '0;
          upws     <= 1'b0;
          updi     <= '0;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          req_ack  <= '0;
          req_rdat <= '0;
`ifdef PCFG_ARB_ERR_EN
          req_err  <= 1'b0;
`endif
          rr_ptr   <= rr_next;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcfg_arb.sv
// tb_pcfg_arb
//   Directed bench for pcfg_arb with NREQ=2, AW=4, DW=8, NREG=12. A 12-entry
//   register bank model supplies updo_or (zero when not enabled) and takes
//   writes on upen&upws. Outputs are sampled 1 ns after the rising edge.
module tb_pcfg_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_vld;
  logic [1:0]  req_wr;
  logic [7:0]  req_addr;
  logic [15:0] req_wdat;
  logic [1:0]  req_ack;
  logic [7:0]  req_rdat;
  logic [11:0] upen;
  logic        upws;
  logic [7:0]  updi;
  logic [7:0]  updo_or;
  logic        busy;
`ifdef PCFG_ARB_ERR_EN
  logic        req_err;
`endif

  logic [7:0]  bank [12];
  int          totalCount;
  int          passCount;

  pcfg_arb #(
    .NREQ (2),
    .AW   (4),
    .DW   (8),
    .NREG (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdat (req_wdat),
    .req_ack  (req_ack),
    .req_rdat (req_rdat),
    .upen     (upen),
    .upws     (upws),
    .updi     (updi),
    .updo_or  (updo_or),
`ifdef PCFG_ARB_ERR_EN
    .req_err  (req_err),
`endif
    .busy     (busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank read path: OR of enabled registers, zero when nothing is enabled.
  always_comb begin
    updo_or = '0;
    for (int r = 0; r < 12; r++) begin
      if (upen[r]) updo_or = updo_or | bank[r];
    end
  end

  // Bank write path: enabled registers take updi on a strobed edge.
  always @(posedge clk) begin
    for (int r = 0; r < 12; r++) begin
      if (upen[r] && upws) bank[r] <= updi;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] vld, input logic [1:0] wr,
                               input logic [3:0] a0, input logic [3:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
    req_vld  = vld;
    req_wr   = wr;
    req_addr = {a1, a0};
    req_wdat = {d1, d0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " upen"},     32'(upen),     32'h0);
    checkOutput({tag, " upws"},     32'(upws),     32'h0);
    checkOutput({tag, " updi"},     32'(updi),     32'h0);
    checkOutput({tag, " req_ack"},  32'(req_ack),  32'h0);
    checkOutput({tag, " req_rdat"}, 32'(req_rdat), 32'h0);
    checkOutput({tag, " busy"},     32'(busy),     32'h0);
  endtask

  // Directed sequence: reset, write, read, out-of-range, contention with a
  // mid-run reset, and an abort during ACC.
  initial begin
    totalCount = 0;
    passCount  = 0;
    for (int r = 0; r < 12; r++) bank[r] = 8'h00;
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    repeat (2) tick();
    checkIdleOutputs("reset");
    @(negedge clk) rst = 1'b0;
    tick();

    // Write: requester 0 writes 0xA5 to register 3.
    applyStimulus(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
    tick();
    checkOutput("wr upen", 32'(upen), 32'h008);
    checkOutput("wr upws", 32'(upws), 32'h1);
    checkOutput("wr updi", 32'(updi), 32'hA5);
    checkOutput("wr busy", 32'(busy), 32'h1);
    checkOutput("wr early ack", 32'(req_ack), 32'h0);
    tick();
    checkOutput("wr ack", 32'(req_ack), 32'h1);
    checkOutput("wr rdat prewrite", 32'(req_rdat), 32'h00);
    checkOutput("wr upen cleared", 32'(upen), 32'h000);
    checkOutput("wr bank3", 32'(bank[3]), 32'hA5);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    tick();
    checkOutput("wr ack drop", 32'(req_ack), 32'h0);
    checkOutput("wr busy drop", 32'(busy), 32'h0);

    // Read: requester 1 reads register 3.
    applyStimulus(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00);
    tick();
    checkOutput("rd upen", 32'(upen), 32'h008);
    checkOutput("rd upws", 32'(upws), 32'h0);
    tick();
    checkOutput("rd ack", 32'(req_ack), 32'h2);
    checkOutput("rd rdat", 32'(req_rdat), 32'hA5);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    tick();
    checkOutput("rd rdat drop", 32'(req_rdat), 32'h00);

    // Out of range: requester 0 writes 0xFF to address 13.
    applyStimulus(2'b01, 2'b01, 4'd13, 4'd0, 8'hFF, 8'h00);
    tick();
    checkOutput("oor upen", 32'(upen), 32'h000);
    tick();
    checkOutput("oor ack", 32'(req_ack), 32'h1);
    checkOutput("oor rdat", 32'(req_rdat), 32'h00);
`ifdef PCFG_ARB_ERR_EN
    checkOutput("oor err", 32'(req_err), 32'h1);
`endif
    checkOutput("oor bank1", 32'(bank[1]), 32'h00);
    checkOutput("oor bank3", 32'(bank[3]), 32'hA5);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    tick();
`ifdef PCFG_ARB_ERR_EN
    checkOutput("oor err drop", 32'(req_err), 32'h0);
`endif

    // Contention from reset: req0 reads reg 3, req1 reads reg 5.
    rst = 1'b1;
    applyStimulus(2'b11, 2'b00, 4'd3, 4'd5, 8'h00, 8'h00);
    tick();
    @(negedge clk) rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      checkOutput($sformatf("cont%0d upen", n), 32'(upen), (n % 2 == 0) ? 32'h008 : 32'h020);
      checkOutput($sformatf("cont%0d ack0", n), 32'(req_ack), 32'h0);
      tick();
      checkOutput($sformatf("cont%0d ack", n), 32'(req_ack), (n % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput($sformatf("cont%0d rdat", n), 32'(req_rdat), (n % 2 == 0) ? 32'hA5 : 32'h00);
      tick();
      checkOutput($sformatf("cont%0d idle", n), 32'(busy), 32'h0);
    end

    // Mid-run reset while DONE holds ack and nonzero read data.
    tick();
    tick();
    checkOutput("mid ack", 32'(req_ack), 32'h1);
    checkOutput("mid rdat", 32'(req_rdat), 32'hA5);
    rst = 1'b1;
    #1;
    checkIdleOutputs("mid reset");

    // Abort: req0 writes 0x3C to reg 7, reset hits during ACC.
    applyStimulus(2'b11, 2'b01, 4'd7, 4'd5, 8'h3C, 8'h00);
    @(negedge clk) rst = 1'b0;
    tick();
    checkOutput("abort pre upen", 32'(upen), 32'h080);
    checkOutput("abort pre upws", 32'(upws), 32'h1);
    #1 rst = 1'b1;
    #1;
    checkIdleOutputs("abort");
    tick();
    checkOutput("abort no ack", 32'(req_ack), 32'h0);
    checkOutput("abort bank7", 32'(bank[7]), 32'h00);
    @(negedge clk) rst = 1'b0;
    tick();
    checkOutput("abort regrant upen", 32'(upen), 32'h080);
    tick();
    checkOutput("abort regrant ack", 32'(req_ack), 32'h1);
    checkOutput("abort regrant bank7", 32'(bank[7]), 32'h3C);
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    tick();

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
